// File: rtl/cpa_multiword_seq.sv
// Sequential wide adder: one SLICE_W-bit slice reused over WORDS words, LSW first.
// Optional subtract mode (port sub) is enabled by defining CPA_SEQ_SUB_EN.
module cpa_multiword_seq #(
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned WORDS   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
`ifdef CPA_SEQ_SUB_EN
  input  logic                       sub,
`endif
  input  logic [SLICE_W*WORDS-1:0]   a_in,
  input  logic [SLICE_W*WORDS-1:0]   b_in,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*WORDS-1:0]   sum_out,
  output logic                       carry_out
);

  localparam int unsigned W    = SLICE_W * WORDS;
  localparam int unsigned IdxW = $clog2(WORDS);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q, carry_out_q, busy_q, done_q;

  logic [SLICE_W-1:0] a_word, b_word, slice_s;
  logic [SLICE_W:0]   slice_full;
  logic               slice_c, accept, last_word, cin_init, sub_in, sub_q;

  assign accept    = start && (state_q == StIdle || state_q == StDone);
  assign last_word = (idx_q == IdxW'(WORDS - 1));

`ifdef CPA_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  // Subtraction is A + ~B + 1, so the word-0 carry-in equals the sub flag.
  assign cin_init = sub_in;

  always_comb begin
    a_word = a_q[idx_q*SLICE_W +: SLICE_W];
    b_word = b_q[idx_q*SLICE_W +: SLICE_W];
    if (sub_q) b_word = ~b_word;
    slice_full = (SLICE_W+1)'(a_word) + (SLICE_W+1)'(b_word) + (SLICE_W+1)'(carry_q);
    slice_s    = slice_full[SLICE_W-1:0];
    slice_c    = slice_full[SLICE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (accept) begin
            a_q         <= a_in;
            b_q         <= b_in;
            sub_q       <= sub_in;
            carry_q     <= cin_init;
            idx_q       <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StAdd;
          end else begin
            state_q <= StIdle;
          end
        end
        StAdd: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_s;
          carry_q <= slice_c;
          idx_q   <= idx_q + 1'b1;
          if (last_word) begin
            carry_out_q <= slice_c;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_out   = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_cpa_multiword_seq.sv
// Scoreboard bench for cpa_multiword_seq: expected sums queued at start, checked on done.
module tb_cpa_multiword_seq;

  localparam int unsigned SLICE_W = 16;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned W       = SLICE_W * WORDS;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub_r = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum_out;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  cpa_multiword_seq #(.SLICE_W(SLICE_W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef CPA_SEQ_SUB_EN
    .sub       (sub_r),
`endif
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] full;
    exp_t       e;
    if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   full = {1'b0, a} + {1'b0, b};
    e.sum   = full[W-1:0];
    e.carry = full[W];
    return e;
  endfunction

  // Drive an accepted start at the current negedge and queue the expected result.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sub_r = s;
    sb_q.push_back(model(a, b, s));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e = model(a, b, s);
    @(negedge clk);
    drive_start(a, b, s);
    for (int c = 1; c <= WORDS + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a_in  = {$urandom, $urandom};
        b_in  = {$urandom, $urandom};
      end
      if (c <= WORDS) begin
        check_val("busy_during_add", busy, 1);
        check_val("done_during_add", done, 0);
      end else begin
        check_val("busy_at_done", busy, 0);
        check_val("done_latency", done, 1);
      end
    end
    @(negedge clk);
    check_val("done_pulse_width", done, 0);
    check_val("sum_held", sum_out, e.sum);
    check_val("carry_held", carry_out, e.carry);
  endtask

  // Scoreboard consumer and busy/done exclusivity monitor.
  always @(negedge clk) begin
    if (!rst && done) begin
      check_val("sb_pending", (sb_q.size() > 0) ? 1 : 0, 1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("sum_out", sum_out, e.sum);
        check_val("carry_out", carry_out, e.carry);
      end
      check_val("busy_done_excl", busy, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e2;
    int   done_gap;
    #12 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sum", sum_out, 0);
    check_val("rst_carry", carry_out, 0);

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    for (int i = 0; i < 4; i++) run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

    // start held high with changing operands; second op accepted in the DONE cycle
    @(negedge clk);
    drive_start(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_0000, 1'b0);
    for (int c = 1; c <= WORDS; c++) begin
      @(negedge clk);
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
    end
    @(negedge clk);
    check_val("b2b_first_done", done, 1);
    drive_start(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    e2 = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check_val("b2b_busy_no_bubble", busy, 1);
    done_gap = 1;
    while (!done && done_gap < 20) begin
      @(negedge clk);
      done_gap++;
    end
    check_val("b2b_done_gap", done_gap, WORDS + 1);
    @(negedge clk);
    check_val("b2b_sum_held", sum_out, e2.sum);

    // asynchronous reset during the second ADD cycle
    @(negedge clk);
    drive_start(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    check_val("arst_sum", sum_out, 0);
    check_val("arst_carry", carry_out, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (WORDS + 3) @(negedge clk);
    check_val("arst_no_done", done, 0);
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);

`ifdef CPA_SEQ_SUB_EN
    run_op(64'h5, 64'h7, 1'b1);
    run_op(64'h7, 64'h5, 1'b1);
    run_op(64'h5, 64'h5, 1'b1);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check_val("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
